// File: rtl/hub75_fb_stream_feed_if.sv
// Stream and row-buffer write bus for hub75_fb_stream_feed.
// The master modport is the feeder's view: it consumes the pixel stream and
// drives the row-buffer write port plus the per-row commit strobes. The slave
// modport is the view of the surrounding logic (pixel source and write-in stage).
// Optional feature macro: HUB75_FEED_RGB565_EN narrows in_data to 16-bit RGB565.
interface hub75_fb_stream_feed_if #(
  parameter int N_BANKS  = 2,
  parameter int N_ROWS   = 32,
  parameter int N_COLS   = 64,
  parameter int BITDEPTH = 24
);
  localparam int LOG_N_BANKS = $clog2(N_BANKS);
  localparam int LOG_N_ROWS  = $clog2(N_ROWS);
  localparam int LOG_N_COLS  = $clog2(N_COLS);
`ifdef HUB75_FEED_RGB565_EN
  localparam int IN_W = 16;
`else
  localparam int IN_W = BITDEPTH;
`endif

  // Pixel stream
  logic [IN_W-1:0]        in_data;
  logic                   in_sof;
  logic                   in_valid;
  logic                   in_ready;

  // Row commit towards the write-in stage
  logic [LOG_N_BANKS-1:0] wr_bank_addr;
  logic [LOG_N_ROWS-1:0]  wr_row_addr;
  logic                   wr_row_store;
  logic                   wr_row_rdy;
  logic                   wr_row_swap;

  // Row-buffer write port
  logic [BITDEPTH-1:0]    wr_data;
  logic [LOG_N_COLS-1:0]  wr_col_addr;
  logic                   wr_en;

  // Status pulses
  logic                   frame_done;
  logic                   sof_err;

  modport master (
    input  in_data, in_sof, in_valid, wr_row_rdy,
    output in_ready, wr_bank_addr, wr_row_addr, wr_row_store, wr_row_swap,
           wr_data, wr_col_addr, wr_en, frame_done, sof_err
  );

  modport slave (
    output in_data, in_sof, in_valid, wr_row_rdy,
    input  in_ready, wr_bank_addr, wr_row_addr, wr_row_store, wr_row_swap,
           wr_data, wr_col_addr, wr_en, frame_done, sof_err
  );
endinterface

// File: rtl/hub75_fb_stream_feed.sv
// hub75_fb_stream_feed: turns a raster-ordered valid/ready pixel stream into
// row-buffer writes and one swap+store commit per completed row. Frame line L
// lands in bank L / N_ROWS, row L % N_ROWS. A row fills in FILL; WAIT holds the
// stream until the write-in stage is idle, then the commit swaps the double
// buffer so the next row can fill while the previous one is copied out.
// Optional feature macro: HUB75_FEED_RGB565_EN (16-bit RGB565 input expanded to
// 24-bit RGB888 in the input register stage; BITDEPTH must then be 24).
module hub75_fb_stream_feed #(
  parameter int N_BANKS  = 2,
  parameter int N_ROWS   = 32,
  parameter int N_COLS   = 64,
  parameter int BITDEPTH = 24
) (
  input  logic                      clk,
  input  logic                      rst,
  hub75_fb_stream_feed_if.master    bus
);
  localparam int LOG_N_BANKS = $clog2(N_BANKS);
  localparam int LOG_N_ROWS  = $clog2(N_ROWS);
  localparam int LOG_N_COLS  = $clog2(N_COLS);
  localparam int LINE_W      = LOG_N_BANKS + LOG_N_ROWS;

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]             state;
  logic [LOG_N_COLS-1:0]  col;
  logic [LINE_W-1:0]      line;
  logic [LOG_N_BANKS-1:0] bank_hold;
  logic [LOG_N_ROWS-1:0]  row_hold;

  logic                   hs;
  logic                   resync;
  logic                   commit;
  logic [BITDEPTH-1:0]    px;

  // Stream handshake; a frame start anywhere but line 0 / col 0 is a resync.
  assign bus.in_ready = (state == ST_FILL);
  assign hs           = bus.in_valid && (state == ST_FILL);
  assign resync       = hs && bus.in_sof && ((col != '0) || (line != '0));

  // The commit is taken in the same cycle the write-in stage reports idle, so a
  // full row costs only one stall cycle; reset suppresses a commit in flight.
  assign commit           = (state == ST_WAIT) && bus.wr_row_rdy && !rst;
  assign bus.wr_row_store = commit;
  assign bus.wr_row_swap  = commit;
  assign bus.frame_done   = commit && (&line);
  assign bus.wr_bank_addr = commit ? line[LINE_W-1 -: LOG_N_BANKS] : bank_hold;
  assign bus.wr_row_addr  = commit ? line[LOG_N_ROWS-1:0] : row_hold;

  // Input pixel formatting ahead of the write register.
`ifdef HUB75_FEED_RGB565_EN
  assign px = {bus.in_data[15:11], bus.in_data[15:13],
               bus.in_data[10:5],  bus.in_data[10:9],
               bus.in_data[4:0],   bus.in_data[4:2]};
`else
  assign px = bus.in_data;
`endif

  // Row/line sequencing: column counter, FILL/WAIT control and commit address hold.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    if (rst) begin
      state     <= ST_FILL;
      col       <= '0;
      line      <= '0;
      bank_hold <= '0;
      row_hold  <= '0;
    end else if (commit) begin
      state     <= ST_FILL;
      line      <= line + LINE_W'(1);
      bank_hold <= line[LINE_W-1 -: LOG_N_BANKS];
      row_hold  <= line[LOG_N_ROWS-1:0];
    end else if (hs) begin
      if (resync) begin
        line <= '0;
        col  <= LOG_N_COLS'(1);
      end else if (&col) begin
        col   <= '0;
        state <= ST_WAIT;
      end else begin
        col <= col + LOG_N_COLS'(1);
      end
    end
  end

  // Row-buffer write port: accepted pixel appears one cycle after its handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.wr_en       <= 1'b0;
      bus.wr_data     <= '0;
      bus.wr_col_addr <= '0;
      bus.sof_err     <= 1'b0;
    end else begin
      bus.wr_en   <= hs;
      bus.sof_err <= resync;
      if (hs) begin
        bus.wr_data     <= px;
        bus.wr_col_addr <= resync ? '0 : col;
      end
    end
  end
endmodule

// File: tb/tb_hub75_fb_stream_feed.sv
// Directed self-checking bench for hub75_fb_stream_feed (2 banks x 32 rows x 64 cols).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge by a passive monitor that logs writes, commits and pulses.
module tb_hub75_fb_stream_feed;
  localparam int N_BANKS  = 2;
  localparam int N_ROWS   = 32;
  localparam int N_COLS   = 64;
  localparam int BITDEPTH = 24;
`ifdef HUB75_FEED_RGB565_EN
  localparam int IW = 16;
`else
  localparam int IW = BITDEPTH;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hub75_fb_stream_feed_if #(.N_BANKS(N_BANKS), .N_ROWS(N_ROWS), .N_COLS(N_COLS),
                            .BITDEPTH(BITDEPTH)) bus ();

  hub75_fb_stream_feed #(.N_BANKS(N_BANKS), .N_ROWS(N_ROWS), .N_COLS(N_COLS),
                         .BITDEPTH(BITDEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  // Monitor logs
  logic [5:0]          col_q[$];
  logic [BITDEPTH-1:0] data_q[$];
  logic [0:0]          st_bank_q[$];
  logic [4:0]          st_row_q[$];
  int                  fd_cnt, fd_at, sof_cnt, nrdy_cnt, swap_bad;

  // Expected row-buffer word for a given input pixel.
  function automatic logic [BITDEPTH-1:0] exp_px(input logic [IW-1:0] d);
`ifdef HUB75_FEED_RGB565_EN
    return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
`else
    return d;
`endif
  endfunction

  // Passive monitor on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.wr_en) begin
        col_q.push_back(bus.wr_col_addr);
        data_q.push_back(bus.wr_data);
      end
      if (bus.wr_row_store) begin
        st_bank_q.push_back(bus.wr_bank_addr);
        st_row_q.push_back(bus.wr_row_addr);
      end
      if (bus.wr_row_store !== bus.wr_row_swap) swap_bad++;
      if (bus.frame_done) begin
        fd_cnt++;
        fd_at = st_bank_q.size();
      end
      if (bus.sof_err) sof_cnt++;
      if (!bus.in_ready) nrdy_cnt++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    col_q.delete(); data_q.delete(); st_bank_q.delete(); st_row_q.delete();
    fd_cnt = 0; fd_at = 0; sof_cnt = 0; nrdy_cnt = 0; swap_bad = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_sof = 1'b0;
    idle(2);
    rst = 1'b0;
    clear_logs();
  endtask

  // One pixel; returns 1 unit after the edge that accepted it.
  task automatic send(input logic [IW-1:0] d, input logic sof);
    int budget = 200;
    bus.in_data  = d;
    bus.in_sof   = sof;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic send_row(input int base, input logic sof);
    for (int c = 0; c < N_COLS; c++) send(IW'(base + c), sof && (c == 0));
  endtask

  // Count write-log entries whose column does not equal their position.
  function automatic int col_errs();
    int e = 0;
    for (int i = 0; i < col_q.size(); i++) if (col_q[i] !== 6'(i % N_COLS)) e++;
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_sof = 1'b0;
    bus.wr_row_rdy = 1'b0;
    bus.in_data = '0;
    idle(3);
    @(negedge clk);
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_in_ready: got %b, want 1", bus.in_ready);
    end
    tests++;
    if ({bus.wr_en, bus.wr_row_store, bus.wr_row_swap, bus.frame_done, bus.sof_err} !== 5'b0) begin
      fails++;
      $display("FAIL reset_pulses: got en/store/swap/fd/err=%b%b%b%b%b, want 00000",
               bus.wr_en, bus.wr_row_store, bus.wr_row_swap, bus.frame_done, bus.sof_err);
    end
    tests++;
    if ({bus.wr_bank_addr, bus.wr_row_addr, bus.wr_col_addr} !== 12'd0 || bus.wr_data !== '0) begin
      fails++;
      $display("FAIL reset_addr: got bank=%0d row=%0d col=%0d data=%h, want all 0",
               bus.wr_bank_addr, bus.wr_row_addr, bus.wr_col_addr, bus.wr_data);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic test_single_row();
    int e = 0;
    bus.wr_row_rdy = 1'b1;
    send_row(0, 1'b1);
    idle(3);
    for (int i = 0; i < data_q.size(); i++) if (data_q[i] !== exp_px(IW'(i))) e++;
    tests++;
    if (col_q.size() != 64 || col_errs() != 0 || e != 0) begin
      fails++;
      $display("FAIL row_writes: got %0d writes, %0d bad cols, %0d bad data; want 64,0,0",
               col_q.size(), col_errs(), e);
    end
    tests++;
    if (st_bank_q.size() != 1 || st_bank_q[0] !== 1'b0 || st_row_q[0] !== 5'd0) begin
      fails++;
      $display("FAIL row_commit: got %0d stores (first bank/row %0d/%0d), want 1 store 0/0",
               st_bank_q.size(), st_bank_q.size() ? st_bank_q[0] : 0, st_row_q.size() ? st_row_q[0] : 0);
    end
    tests++;
    if (nrdy_cnt != 1) begin
      fails++; $display("FAIL row_stall: in_ready low %0d cycles, want 1", nrdy_cnt);
    end
    tests++;
    if (swap_bad != 0 || sof_cnt != 0) begin
      fails++; $display("FAIL row_pulses: swap/store disagree %0d, sof_err %0d; want 0,0", swap_bad, sof_cnt);
    end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    clear_logs();
    bus.wr_row_rdy = 1'b0;
    send_row(100, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.wr_row_store || bus.wr_row_swap || bus.in_ready) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL bp_hold: %0d cycles with store/swap/in_ready high, want 0", bad);
    end
    @(posedge clk);
    #1;
    bus.wr_row_rdy = 1'b1;
    @(negedge clk);
    tests++;
    if (!(bus.wr_row_store && bus.wr_row_swap) || bus.wr_bank_addr !== 1'b0 || bus.wr_row_addr !== 5'd1) begin
      fails++;
      $display("FAIL bp_release: got store=%b swap=%b bank=%0d row=%0d, want 1 1 0 1",
               bus.wr_row_store, bus.wr_row_swap, bus.wr_bank_addr, bus.wr_row_addr);
    end
    @(posedge clk);
    #1;
    send_row(200, 1'b0);
    idle(3);
    tests++;
    if (st_bank_q.size() != 2 || st_bank_q[1] !== 1'b0 || st_row_q[1] !== 5'd2) begin
      fails++; $display("FAIL bp_next_row: got %0d stores, want 2 ending bank 0 row 2", st_bank_q.size());
    end
    tests++;
    if (nrdy_cnt != 22 || col_q.size() != 128 || col_errs() != 0) begin
      fails++;
      $display("FAIL bp_stream: in_ready low %0d, writes %0d, bad cols %0d; want 22,128,0",
               nrdy_cnt, col_q.size(), col_errs());
    end
  endtask

  task automatic test_full_frame();
    do_reset();
    bus.wr_row_rdy = 1'b1;
    for (int r = 0; r < 65; r++) send_row(r, r == 0);
    idle(3);
    tests++;
    if (st_bank_q.size() != 65) begin
      fails++; $display("FAIL frame_stores: got %0d, want 65", st_bank_q.size());
    end else begin
      tests++;
      if (st_bank_q[31] !== 1'b0 || st_row_q[31] !== 5'd31 || st_bank_q[32] !== 1'b1 || st_row_q[32] !== 5'd0) begin
        fails++;
        $display("FAIL frame_bank_edge: store32 %0d/%0d store33 %0d/%0d, want 0/31 1/0",
                 st_bank_q[31], st_row_q[31], st_bank_q[32], st_row_q[32]);
      end
      tests++;
      if (st_bank_q[63] !== 1'b1 || st_row_q[63] !== 5'd31 || st_bank_q[64] !== 1'b0 || st_row_q[64] !== 5'd0) begin
        fails++;
        $display("FAIL frame_wrap: store64 %0d/%0d store65 %0d/%0d, want 1/31 0/0",
                 st_bank_q[63], st_row_q[63], st_bank_q[64], st_row_q[64]);
      end
    end
    tests++;
    if (fd_cnt != 1 || fd_at != 64) begin
      fails++; $display("FAIL frame_done: %0d pulses at store %0d, want 1 at 64", fd_cnt, fd_at);
    end
  endtask

  task automatic test_sof_resync();
    do_reset();
    bus.wr_row_rdy = 1'b1;
    for (int r = 0; r < 5; r++) send_row(r * 64, r == 0);
    for (int c = 0; c < 17; c++) send(IW'(c), 1'b0);
    idle(2);
    clear_logs();
    send(IW'(8'hAB), 1'b1);
    for (int c = 1; c < N_COLS; c++) send(IW'(c), 1'b0);
    idle(3);
    tests++;
    if (sof_cnt != 1) begin
      fails++; $display("FAIL sof_err_pulse: got %0d pulses, want 1", sof_cnt);
    end
    tests++;
    if (col_q.size() != 64 || col_errs() != 0 || data_q[0] !== exp_px(IW'(8'hAB))) begin
      fails++;
      $display("FAIL sof_writes: got %0d writes, %0d bad cols, first data %h; want 64,0,%h",
               col_q.size(), col_errs(), data_q.size() ? data_q[0] : '0, exp_px(IW'(8'hAB)));
    end
    tests++;
    if (st_bank_q.size() != 1 || st_bank_q[0] !== 1'b0 || st_row_q[0] !== 5'd0) begin
      fails++;
      $display("FAIL sof_commit: got %0d stores (first row %0d), want 1 store bank 0 row 0",
               st_bank_q.size(), st_row_q.size() ? st_row_q[0] : 0);
    end
  endtask

  task automatic test_mid_row_reset();
    do_reset();
    bus.wr_row_rdy = 1'b1;
    for (int c = 0; c < 30; c++) send(IW'(c), c == 0);
    rst = 1'b1;
    bus.in_data = IW'(30);
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (bus.wr_en !== 1'b0 || bus.in_ready !== 1'b1 || bus.wr_row_store !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_row: got wr_en=%b in_ready=%b store=%b, want 0 1 0",
               bus.wr_en, bus.in_ready, bus.wr_row_store);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    clear_logs();
    send_row(0, 1'b0);
    idle(3);
    tests++;
    if (st_bank_q.size() != 1 || st_bank_q[0] !== 1'b0 || st_row_q[0] !== 5'd0 ||
        col_q.size() != 64 || col_errs() != 0) begin
      fails++;
      $display("FAIL rst_recover: got %0d stores, %0d writes, %0d bad cols; want 1 (0/0),64,0",
               st_bank_q.size(), col_q.size(), col_errs());
    end
  endtask

`ifdef HUB75_FEED_RGB565_EN
  task automatic test_rgb565();
    do_reset();
    bus.wr_row_rdy = 1'b1;
    send(16'hF800, 1'b1);
    send(16'h07E0, 1'b0);
    idle(2);
    tests++;
    if (data_q.size() != 2 || data_q[0] !== 24'hFF0000 || data_q[1] !== 24'h00FF00) begin
      fails++;
      $display("FAIL rgb565: got %0d writes first %h second %h, want ff0000 00ff00",
               data_q.size(), data_q.size() > 0 ? data_q[0] : '0, data_q.size() > 1 ? data_q[1] : '0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_row();
    test_backpressure();
    test_full_frame();
    test_sof_resync();
    test_mid_row_reset();
`ifdef HUB75_FEED_RGB565_EN
    test_rgb565();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
